// File: rtl/debug_ocimem_ctrl.sv
// OCI debug-memory controller: turns JTAG take_* pulses into OCI RAM reads/writes
// and shares the single RAM port with CPU Avalon-MM accesses (JTAG wins).
module debug_ocimem_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int RESET_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [31:0]       ram_rdata,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest
);

    typedef enum logic [1:0] {IDLE, J_RD, C_RD} state_t;
    typedef enum logic [1:0] {CMD_A, CMD_B, CMD_NA} cmd_t;

    state_t            state_q, state_d;
    logic              pend_valid_q, pend_valid_d;
    cmd_t              pend_cmd_q, pend_cmd_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_rd_q, pend_rd_d;
    logic [31:0]       pend_wdata_q, pend_wdata_d;
    logic [ADDR_W-1:0] jaddr_q, jaddr_d;
    logic [31:0]       mon_dreg_q, mon_dreg_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic [31:0]       rdata_q, rdata_d;

    logic any_take, multi_take, jtag_busy;
    logic unused_jdo;

    assign any_take   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign multi_take = (take_action_ocimem_a & take_action_ocimem_b) |
                        (take_action_ocimem_a & take_no_action_ocimem_a) |
                        (take_action_ocimem_b & take_no_action_ocimem_a);
    // A pulse in flight already counts as JTAG work so the CPU cannot slip in ahead of it.
    assign jtag_busy  = pend_valid_q | any_take;
    assign unused_jdo = ^jdo;

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_cmd_d   = pend_cmd_q;
        pend_addr_d  = pend_addr_q;
        pend_rd_d    = pend_rd_q;
        pend_wdata_d = pend_wdata_q;
        jaddr_d      = jaddr_q;
        mon_dreg_d   = mon_dreg_q;
        ready_d      = ready_q;
        error_d      = error_q;
        rdata_d      = rdata_q;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        ram_addr     = avs_address;
        ram_wdata    = avs_writedata;

        // Capture into the one-deep slot; overruns and collisions only raise the sticky flag.
        if (any_take) begin
            if (pend_valid_q || multi_take) begin
                error_d = 1'b1;
            end
            if (!pend_valid_q) begin
                pend_valid_d = 1'b1;
                ready_d      = 1'b0;
                pend_addr_d  = jdo[ADDR_W+25:26];
                pend_rd_d    = jdo[17];
                pend_wdata_d = jdo[34:3];
                if (take_action_ocimem_b) begin
                    pend_cmd_d = CMD_B;
                end else if (take_action_ocimem_a) begin
                    pend_cmd_d = CMD_A;
                    if (jdo[18] && !multi_take) begin
                        error_d = 1'b0;
                    end
                end else begin
                    pend_cmd_d = CMD_NA;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    case (pend_cmd_q)
                        CMD_B: begin
                            ram_we       = 1'b1;
                            ram_addr     = jaddr_q;
                            ram_wdata    = pend_wdata_q;
                            jaddr_d      = jaddr_q + 1'b1;
                            pend_valid_d = 1'b0;
                            ready_d      = 1'b1;
                        end
                        CMD_NA: begin
                            ram_re   = 1'b1;
                            ram_addr = jaddr_q;
                            jaddr_d  = jaddr_q + 1'b1;
                            state_d  = J_RD;
                        end
                        default: begin
                            jaddr_d = pend_addr_q;
                            if (pend_rd_q) begin
                                ram_re   = 1'b1;
                                ram_addr = pend_addr_q;
                                state_d  = J_RD;
                            end else begin
                                pend_valid_d = 1'b0;
                                ready_d      = 1'b1;
                            end
                        end
                    endcase
                end else if (!any_take) begin
                    if (avs_read) begin
                        ram_re  = 1'b1;
                        state_d = C_RD;
                    end else if (avs_write) begin
                        ram_we = 1'b1;
                    end
                end
            end
            J_RD: begin
                mon_dreg_d   = ram_rdata;
                ready_d      = 1'b1;
                pend_valid_d = 1'b0;
                state_d      = IDLE;
            end
            C_RD: begin
                rdata_d = ram_rdata;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (reset) begin
            ram_we = 1'b0;
            ram_re = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_valid_q <= 1'b0;
            pend_cmd_q   <= CMD_A;
            pend_addr_q  <= '0;
            pend_rd_q    <= 1'b0;
            pend_wdata_q <= '0;
            jaddr_q      <= ADDR_W'(RESET_ADDR);
            mon_dreg_q   <= '0;
            ready_q      <= 1'b1;
            error_q      <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_cmd_q   <= pend_cmd_d;
            pend_addr_q  <= pend_addr_d;
            pend_rd_q    <= pend_rd_d;
            pend_wdata_q <= pend_wdata_d;
            jaddr_q      <= jaddr_d;
            mon_dreg_q   <= mon_dreg_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
            rdata_q      <= rdata_d;
        end
    end

    assign MonDReg       = mon_dreg_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;
    // Read data is forwarded in the C_RD cycle so it is valid while waitrequest is low.
    assign avs_readdata  = (state_q == C_RD && !reset) ? ram_rdata : rdata_q;
    assign avs_waitrequest = reset || (state_q == J_RD) || jtag_busy ||
                             (state_q == IDLE && avs_read);

endmodule

// File: doc/debug_ocimem_ctrl.md
Name: debug_ocimem_ctrl

Overview:
- Downstream consumer of the Nios II debug-slave JTAG front end.
- Decodes the system-clock-domain `take_action_ocimem_*` pulses and the `jdo` payload into reads and writes of the on-chip debug memory (OCI RAM).
- Arbitrates that traffic against CPU Avalon-MM accesses to the same RAM.
- Returns read data and status to the front end through `MonDReg`, `monitor_ready` and `monitor_error`.

Parameters:
- ADDR_W, 8, OCI RAM word-address width; depth is 2^ADDR_W words of 32 bits.
- RESET_ADDR, 0, value the JTAG address counter takes at reset.

Ports:
- clk  in  1  system clock; every register is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- jdo  in  38  JTAG data payload; valid in the cycle of a take_* pulse.
- take_action_ocimem_a  in  1  one-cycle pulse; address load, with optional read.
- take_action_ocimem_b  in  1  one-cycle pulse; write `jdo[34:3]` at the counter address.
- take_no_action_ocimem_a  in  1  one-cycle pulse; streaming read at the counter address.
- MonDReg  out  32  last JTAG read data.
- monitor_ready  out  1  high when no JTAG operation is outstanding.
- monitor_error  out  1  sticky overrun/collision flag.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe.
- ram_rdata  in  32  RAM read data; valid exactly 1 cycle after `ram_re`.
- avs_address  in  ADDR_W  CPU word address.
- avs_read  in  1  CPU read request.
- avs_write  in  1  CPU write request.
- avs_writedata  in  32  CPU write data.
- avs_readdata  out  32  CPU read data.
- avs_waitrequest  out  1  Avalon stall.

Behaviour:
- Reset values: state IDLE; pending slot empty; address counter `jaddr` = RESET_ADDR; `MonDReg` = 0; `monitor_ready` = 1; `monitor_error` = 0; `ram_we` = `ram_re` = 0; `avs_readdata` = 0.
- Reset asserted mid-operation aborts the operation. Any pending or in-flight command is discarded; no RAM strobe is issued in the cycle after reset.
- JTAG command capture:
  - Any take_* pulse latches the command and `jdo` into a one-deep pending slot, and clears `monitor_ready` on the next edge.
  - Command A: `jaddr` <= `jdo[ADDR_W+25:26]`. A read is then issued if `jdo[17]` = 1. If `jdo[18]` = 1, `monitor_error` is cleared.
  - Command B: write `jdo[34:3]` at `jaddr`, then `jaddr` <= `jaddr` + 1.
  - Command NA: read at `jaddr`, then `jaddr` <= `jaddr` + 1.
  - `jaddr` wraps from 2^ADDR_W - 1 to 0.
- Pulse collisions:
  - If several take_* pulses arrive in one cycle, only the highest priority is captured (B > A > NA), and `monitor_error` is set.
  - A pulse arriving while the pending slot is full is dropped, and `monitor_error` is set.
- FSM states: IDLE, J_RD, C_RD.
- IDLE, JTAG pending (JTAG has priority):
  - Write: `ram_we` for one cycle, slot cleared, `monitor_ready` = 1 on the next edge. Stay in IDLE.
  - Read: `ram_re` for one cycle, go to J_RD.
  - Address-only A: slot cleared, `monitor_ready` = 1 on the next edge.
- J_RD: `MonDReg` <= `ram_rdata`, `monitor_ready` <= 1, slot cleared, go to IDLE. JTAG read latency is 2 clk from capture to `monitor_ready`.
- IDLE, no JTAG pending, `avs_write`: `ram_we` with `avs_address`/`avs_writedata` this cycle; `avs_waitrequest` = 0.
- IDLE, no JTAG pending, `avs_read`: `ram_re`, go to C_RD; `avs_waitrequest` = 1.
- C_RD: `avs_readdata` <= `ram_rdata`, `avs_waitrequest` = 0 this cycle, go to IDLE.
- `avs_waitrequest` (combinational) = 1 when:
  - the state is J_RD; or
  - the pending slot is full or a take_* pulse is present; or
  - the state is IDLE and `avs_read` is asserted; or
  - `reset` is asserted.
- `avs_read` and `avs_write` both asserted: treated as a read; `monitor_error` is unaffected.
- A CPU access that is stalled holds its request; it is never dropped.

Test Plan:
- Reset, then A pulse with `jdo[33:26]` = 8'h10, `jdo[17]` = 0 -> `jaddr` = 0x10; `monitor_ready` dips for 1 cycle then returns to 1; no RAM strobe.
- B pulse with `jdo[34:3]` = 32'hDEADBEEF, then NA after the address is reloaded to 0x10 -> write at 0x10; `MonDReg` = 32'hDEADBEEF 2 clk after the NA; `jaddr` = 0x11.
- `jaddr` = 0xFF, B pulse -> write at 0xFF; `jaddr` wraps to 0x00; `monitor_error` stays 0.
- NA pulse and `avs_read` in the same cycle -> JTAG read served first; `avs_waitrequest` is held until the JTAG read completes; CPU data returns 2 clk later with the correct word.
- Second NA pulse while J_RD is busy and the slot is full -> `monitor_error` = 1 and stays sticky; an A pulse with `jdo[18]` = 1 clears it.
- `reset` asserted in J_RD -> next cycle `monitor_ready` = 1, `MonDReg` = 0, `avs_waitrequest` deasserted after `reset` falls, no stale `ram_re`.
